// File: rtl/reg_bank_sb.sv
// rtl/reg_bank_sb.sv - register file with write bypass and per-register busy scoreboard
module reg_bank_sb #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG  = 0,
    parameter int INIT_MODE = 1,
    parameter int BYPASS    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              ra_busy,
    output logic              rb_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok,
    output logic [ADDR_W:0]   busy_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busyNext;
    logic [ADDR_W:0]   cntNext;
    logic              raBypass;
    logic              rbBypass;
    logic              raZero;
    logic              rbZero;
    logic              wrZero;
    logic              rsvZero;

    always_comb begin
        raZero   = (ZERO_REG != 0) && (ra_addr == '0);
        rbZero   = (ZERO_REG != 0) && (rb_addr == '0);
        wrZero   = (ZERO_REG != 0) && (wr_addr == '0);
        rsvZero  = (ZERO_REG != 0) && (rsv_addr == '0);
        raBypass = (BYPASS != 0) && wr_en && (wr_addr == ra_addr);
        rbBypass = (BYPASS != 0) && wr_en && (wr_addr == rb_addr);

        ra_data = raZero ? '0 : (raBypass ? wr_data : regs[ra_addr]);
        rb_data = rbZero ? '0 : (rbBypass ? wr_data : regs[rb_addr]);
        ra_busy = ~raZero & busy[ra_addr] & ~raBypass;
        rb_busy = ~rbZero & busy[rb_addr] & ~rbBypass;

        rsv_ok = ~busy[rsv_addr] | (wr_en & (wr_addr == rsv_addr));
    end

    // Write clears first so a same-cycle reserve leaves the register owned by the new producer.
    always_comb begin
        busyNext = busy;
        if (wr_en && !wrZero)
            busyNext[wr_addr] = 1'b0;
        if (rsv_en && rsv_ok && !rsvZero)
            busyNext[rsv_addr] = 1'b1;
        cntNext = '0;
        for (int i = 0; i < DEPTH; i++)
            cntNext = cntNext + (ADDR_W+1)'(busyNext[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= (INIT_MODE != 0) ? DATA_W'(i) : '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_en && !wrZero)
                regs[wr_addr] <= wr_data;
            busy     <= busyNext;
            busy_cnt <= cntNext;
        end
    end
endmodule

// File: doc/reg_bank_sb.md
Name: reg_bank_sb

Overview:
Parametrised register file with integrated scoreboard for the pipelined CPU datapath. It provides two asynchronous read ports, one synchronous write port and write-to-read bypass. Per-register busy bits are set at issue (reserve) and cleared at writeback, so decode can detect RAW hazards and stall. It sits between decode/issue (reads, reserve) and writeback (write).

Parameters:
DATA_W, 64, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 0, 1 = register 0 reads as zero, ignores writes and reserves, and is never busy
INIT_MODE, 1, reset contents: 1 = reg[i] = i (zero-extended), 0 = all zero
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
ra_addr  in  ADDR_W  read port A address
rb_addr  in  ADDR_W  read port B address
ra_data  out  DATA_W  read port A data (combinational)
rb_data  out  DATA_W  read port B data (combinational)
ra_busy  out  1  port A register has an outstanding producer
rb_busy  out  1  port B register has an outstanding producer
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback data
rsv_en  in  1  issue reserves a destination register
rsv_addr  in  ADDR_W  register to reserve
rsv_ok  out  1  reserve accepted (combinational)
busy_cnt  out  ADDR_W+1  number of currently busy registers (registered)

Behaviour:
- Reset (rst_n low at a rising edge): reg[i] <= INIT_MODE ? i : 0; all busy bits <= 0; busy_cnt <= 0. wr_en and rsv_en are ignored in that cycle. Read outputs always reflect the current array contents, so the reset values appear after the first reset edge.
- Read: ra_data = reg[ra_addr], with zero latency. If BYPASS=1, wr_en=1 and wr_addr==ra_addr, then ra_data = wr_data. Port B behaves identically.
- ZERO_REG=1: address 0 always reads 0 and reports busy=0, including during bypass.
- Busy outputs: ra_busy = busy[ra_addr] & ~(BYPASS & wr_en & wr_addr==ra_addr). Port B is symmetric. With BYPASS=0, the raw busy bit is reported and the read returns old data.
- Write: on a rising edge with rst_n=1 and wr_en=1, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. Writes to an address that is not busy are legal and simply update the register.
- Reserve: rsv_ok = ~busy[rsv_addr] | (wr_en & wr_addr==rsv_addr). On an edge with rsv_en & rsv_ok, busy[rsv_addr] <= 1. A refused reserve (rsv_ok=0) changes no state; the issuer must stall and retry. This rule forbids WAW on a pending register, so a single busy bit suffices.
- Simultaneous write and reserve to the same address: data is written and busy ends at 1 (reserve wins, new producer).
- Reserve of reg 0 with ZERO_REG=1: rsv_ok=1 and no state changes.
- busy_cnt: updated every edge to the population count of the next busy vector. Concretely, +1 for an accepted reserve of a non-busy register, -1 for a write clearing a busy register, and unchanged when both target the same register. Maximum is DEPTH (or DEPTH-1 with ZERO_REG=1), and it never wraps.
- Reset asserted mid-operation discards all outstanding reservations; the issuing pipeline is also reset.
- Port A and port B reading the same address return identical data and busy.

Test Plan:
- Reset, INIT_MODE=1: hold rst_n=0 for 1 edge, read ra_addr=7, rb_addr=31 -> ra_data=7, rb_data=31, ra_busy=rb_busy=0, busy_cnt=0.
- Write then read: wr_en=1, wr_addr=5, wr_data=0xDEAD_BEEF_0000_0001; the same cycle ra_addr=5 -> ra_data=0xDEAD_BEEF_0000_0001 (bypass). The next cycle with wr_en=0 -> same value from the array.
- Scoreboard: rsv_en=1, rsv_addr=9 -> rsv_ok=1. Next cycle ra_addr=9 -> ra_busy=1, busy_cnt=1. A second rsv to 9 -> rsv_ok=0 and busy_cnt stays 1. wr_en to 9 with data 0x42 -> same-cycle ra_busy=0, ra_data=0x42; next cycle busy_cnt=0.
- Simultaneous write and reserve of reg 12 while it is busy -> rsv_ok=1, reg12=wr_data, busy[12] stays 1, busy_cnt unchanged.
- ZERO_REG=1: write 0xFF to reg 0 and reserve reg 0 -> ra_data(0)=0, ra_busy=0, busy_cnt=0, rsv_ok=1.
- Reset mid-operation: reserve regs 1, 2, 3 (busy_cnt=3), write 0x77 to reg 4, then rst_n=0 for one edge -> busy_cnt=0, all busy=0, reg4=4. An rsv_en in the reset cycle is ignored.
